// File: rtl/sysarr_int_mul.sv
// Sequential signed multiplier for a systolic-array PE: one multiplier bit per cycle,
// result handed to the PE adder through a valid/ready handshake with an overflow flag.
module sysarr_int_mul #(
    parameter int DW = 16,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_prod,
    output logic          out_ovf
);

    localparam int PW = 2 * DW;
    localparam logic [CW-1:0] LastBit = CW'(DW - 1);
    localparam logic [CW-1:0] DoneCnt = CW'(DW);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [DW-1:0] prod_q, prod_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] addend;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        ovf_d    = ovf_q;
        addend   = '0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = {{DW{in_a[DW-1]}}, in_a};
                    mplier_d = in_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == DoneCnt) begin
                    prod_d  = acc_q[DW-1:0];
                    // Exact product fits in PW bits, so overflow is just a bad sign extension.
                    ovf_d   = acc_q[PW-1:DW] != {DW{acc_q[DW-1]}};
                    state_d = StDone;
                end else begin
                    // The top multiplier bit carries negative weight in two's complement.
                    if (mplier_q[0]) begin
                        addend = (cnt_q == LastBit) ? ({PW{1'b0}} - mcand_q) : mcand_q;
                    end
                    acc_d    = acc_q + addend;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_prod  = prod_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sysarr_int_mul.sv
// Scoreboard bench for sysarr_int_mul at DW=8: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_sysarr_int_mul;

    localparam int DW = 8;
    localparam int CW = $clog2(DW + 1);

    logic          clk = 1'b0;
    logic          nRST = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_prod;
    logic          out_ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rnd_phase = 1'b0;
    logic [DW:0] exp_q[$];   // {ovf, prod}

    sysarr_int_mul #(.DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .nRST     (nRST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_prod (out_prod),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Must be called just after a rising edge; returns just after the acceptance edge.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] ep, input logic eo, input bit drop_valid);
        bit got = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (in_ready && nRST) begin
                exp_q.push_back({eo, ep});
                got = 1'b1;
            end
        end
        chk("accept_timeout", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (drop_valid) in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic golden(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] ep, output logic eo);
        logic signed [DW-1:0]   sa, sb;
        logic signed [2*DW-1:0] full;
        sa = a;
        sb = b;
        full = sa * sb;
        ep = full[DW-1:0];
        eo = full[2*DW-1:DW] != {DW{full[DW-1]}};
    endtask

    // Monitor: scoreboard pop on handshake, latency and initiation-interval checks.
    initial begin
        logic [DW:0] e;
        logic prev_v = 1'b0;
        int last_acc = 0;
        bit have_acc = 1'b0;
        forever begin
            @(negedge clk);
            if (!nRST) begin
                prev_v = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    if (have_acc) begin
                        checks++;
                        if (cyc - last_acc < DW + 2) begin
                            errors++;
                            $display("FAIL init_interval: got %0d required >= %0d",
                                     cyc - last_acc, DW + 2);
                        end
                    end
                    last_acc = cyc;
                    have_acc = 1'b1;
                end
                if (out_valid && !prev_v) begin
                    chk("latency", cyc - (last_acc + 1), DW + 1);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got prod 0x%0h ovf %0b required none",
                                 out_prod, out_ovf);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_prod", {24'd0, out_prod}, {24'd0, e[DW-1:0]});
                        chk("out_ovf", {31'd0, out_ovf}, {31'd0, e[DW]});
                    end
                end
                prev_v = out_valid;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_phase) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        logic [DW-1:0] ra, rb, rp;
        logic ro;
        bit bad;

        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_prod", {24'd0, out_prod}, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        #10 nRST = 1'b1;
        @(posedge clk);
        #1;

        // Basic 3*5 with latency and post-handshake in_ready
        out_ready = 1'b1;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        send(8'd3, 8'd5, 8'h0F, 1'b0, 1'b1);
        bad = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                bad = 1'b0;
                break;
            end
        end
        chk("valid_timeout", {31'd0, bad}, 32'd0);
        @(negedge clk);
        chk("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Sign and boundary cases
        send(8'hFD, 8'd5,  8'hF1, 1'b0, 1'b1); drain();
        send(8'h80, 8'd1,  8'h80, 1'b0, 1'b1); drain();
        send(8'h80, 8'hFF, 8'h80, 1'b1, 1'b1); drain();
        send(8'd127, 8'd127, 8'h01, 1'b1, 1'b1); drain();
        send(8'd0, 8'hB3, 8'h00, 1'b0, 1'b1); drain();

        // Backpressure with in_valid toggling and operand churn
        out_ready = 1'b0;
        send(8'd7, 8'hFE, 8'hF2, 1'b0, 1'b1);
        bad = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                bad = 1'b0;
                break;
            end
        end
        chk("bp_valid_timeout", {31'd0, bad}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'(i % 2);
            in_a = 8'(i * 13 + 1);
            in_b = 8'(i * 7 + 3);
            @(negedge clk);
            if (i % 5 == 0) begin
                chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_out_prod", {24'd0, out_prod}, 32'h0000_00F2);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("bp_back_idle", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset mid-operation
        send(8'd9, 8'd9, 8'h51, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        void'(exp_q.pop_back());
        nRST = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_prod", {24'd0, out_prod}, 32'd0);
        #10 nRST = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        chk("no_valid_after_rst", {31'd0, bad}, 32'd0);
        @(posedge clk);
        #1;
        send(8'd2, 8'd3, 8'h06, 1'b0, 1'b1);
        drain();

        // Back-to-back random operands with random backpressure
        rnd_phase = 1'b1;
        for (int n = 0; n < 50; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (n == 0) ra = 8'h80;
            if (n == 1) rb = 8'h00;
            golden(ra, rb, rp, ro);
            send(ra, rb, rp, ro, 1'b0);
        end
        rnd_phase = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
